// File: rtl/runner_pkg.sv
// Shared types and default constants for the runner motion controller.
package runner_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RUN  = 3'd1,
      S_DUCK = 3'd2,
      S_JUMP = 3'd3,
      S_DEAD = 3'd4
   } runner_state_t;

   typedef enum logic [2:0] {
      SPR_STAND  = 3'd0,
      SPR_RUN_A  = 3'd1,
      SPR_RUN_B  = 3'd2,
      SPR_DUCK_A = 3'd3,
      SPR_DUCK_B = 3'd4,
      SPR_DEAD   = 3'd5
   } sprite_sel_t;

   localparam logic        [9:0] RUNNER_X_DEF    = 10'd50;
   localparam logic        [9:0] GROUND_Y_DEF    = 10'd300;
   localparam logic        [9:0] DUCK_DROP_DEF   = 10'd34;
   localparam logic signed [7:0] JUMP_V0_DEF     = 8'sd20;
   localparam logic signed [7:0] GRAVITY_DEF     = 8'sd1;
   localparam int                ANIM_FRAMES_DEF = 10;

endpackage

// File: rtl/runner_anim.sv
// Run/duck animation phase: counts frames while enabled and toggles phase
// every ANIM_FRAMES frames; clr_i restarts the sequence synchronously.
module runner_anim #(
   parameter int ANIM_FRAMES = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic clr_i,
   output logic phase_o,
   output logic phase_nxt_o
);

   localparam int CW = $clog2(ANIM_FRAMES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;

   // NOTE: defaults first so every path assigns every signal -- no latches.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (clr_i) begin
         cnt_d   = CW'(1);
         phase_d = 1'b0;
      end else if (en_i) begin
         if (cnt_q == CW'(ANIM_FRAMES)) begin
            cnt_d   = CW'(1);
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= CW'(1);
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase_o     = phase_q;
   assign phase_nxt_o = phase_d;

endmodule

// File: rtl/runner_motion.sv
// Per-frame runner controller: FSM, jump physics and registered sprite outputs.
// Optional macro RUNNER_FAST_FALL_EN: duck while airborne triples gravity.
module runner_motion
   import runner_pkg::*;
#(
   parameter logic        [9:0] RUNNER_X    = RUNNER_X_DEF,
   parameter logic        [9:0] GROUND_Y    = GROUND_Y_DEF,
   parameter logic        [9:0] DUCK_DROP   = DUCK_DROP_DEF,
   parameter logic signed [7:0] JUMP_V0     = JUMP_V0_DEF,
   parameter logic signed [7:0] GRAVITY     = GRAVITY_DEF,
   parameter int                ANIM_FRAMES = ANIM_FRAMES_DEF
) (
   input  logic       frame_Clk,
   input  logic       Reset_n,
   input  logic       start,
   input  logic       jump,
   input  logic       duck,
   input  logic       collide,
   output logic [9:0] PosX,
   output logic [9:0] PosY,
   output logic [2:0] sprite_sel,
   output logic       airborne,
   output logic       dead
);

   runner_state_t      state_q, state_d;
   logic        [9:0]  h_q, h_d;
   logic signed [7:0]  v_q, v_d;
   logic signed [10:0] s;
   logic signed [7:0]  grav_step;
   logic               anim_en, anim_clr;
   logic               phase, phase_nxt;

   logic [9:0]  posy_q, posy_d;
   sprite_sel_t sprite_q, sprite_d;
   logic        airborne_q, dead_q;

   runner_anim #(.ANIM_FRAMES(ANIM_FRAMES)) u_anim (
      .clk         (frame_Clk),
      .rst_n       (Reset_n),
      .en_i        (anim_en),
      .clr_i       (anim_clr),
      .phase_o     (phase),
      .phase_nxt_o (phase_nxt)
   );

   assign s       = $signed({1'b0, h_q}) + $signed({{3{v_q[7]}}, v_q});
   assign anim_en = (state_q == S_RUN) || (state_q == S_DUCK);

`ifdef RUNNER_FAST_FALL_EN
   assign grav_step = duck ? (GRAVITY + GRAVITY + GRAVITY) : GRAVITY;
`else
   assign grav_step = GRAVITY;
`endif

   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      v_d      = v_q;
      anim_clr = 1'b0;
      unique case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            if (collide)   state_d = S_DEAD;
            else if (jump) begin
               state_d = S_JUMP;
               v_d     = JUMP_V0;
            end else if (duck) state_d = S_DUCK;
         end
         S_DUCK: begin
            if (collide)   state_d = S_DEAD;
            else if (jump) begin
               state_d = S_JUMP;
               v_d     = JUMP_V0;
            end else if (!duck) state_d = S_RUN;
         end
         S_JUMP: begin
            if (collide) state_d = S_DEAD;
            else if (s <= 11'sd0 && v_q <= 8'sd0) begin
               // Landing clamps to the ground so h can never wrap below zero.
               state_d = S_RUN;
               h_d     = 10'd0;
               v_d     = 8'sd0;
            end else begin
               h_d = s[9:0];
               v_d = v_q - grav_step;
            end
         end
         S_DEAD: if (start) begin
            state_d  = S_RUN;
            h_d      = 10'd0;
            v_d      = 8'sd0;
            anim_clr = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are computed from next-state values so they change on the same edge.
   always_comb begin
      posy_d   = (state_d == S_DUCK) ? (GROUND_Y + DUCK_DROP) : (GROUND_Y - h_d);
      sprite_d = SPR_STAND;
      unique case (state_d)
         S_RUN:   sprite_d = phase_nxt ? SPR_RUN_B  : SPR_RUN_A;
         S_DUCK:  sprite_d = phase_nxt ? SPR_DUCK_B : SPR_DUCK_A;
         S_DEAD:  sprite_d = SPR_DEAD;
         default: sprite_d = SPR_STAND;
      endcase
   end

   always_ff @(posedge frame_Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= S_IDLE;
         h_q        <= 10'd0;
         v_q        <= 8'sd0;
         posy_q     <= GROUND_Y;
         sprite_q   <= SPR_STAND;
         airborne_q <= 1'b0;
         dead_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         h_q        <= h_d;
         v_q        <= v_d;
         posy_q     <= posy_d;
         sprite_q   <= sprite_d;
         airborne_q <= (state_d == S_JUMP);
         dead_q     <= (state_d == S_DEAD);
      end
   end

   assign PosX       = RUNNER_X;
   assign PosY       = posy_q;
   assign sprite_sel = sprite_q;
   assign airborne   = airborne_q;
   assign dead       = dead_q;

   logic unused_phase;
   assign unused_phase = phase;

endmodule
